// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over WIDTH cycles.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             cell_s;
    logic             cell_c;

    // Subtraction is a + ~b + 1: invert B on load and force the carry-in.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign cell_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign cell_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy          = 1'b1;
                sum_d[cnt_q]  = cell_s;
                carry_d       = cell_c;
                a_d           = a_q >> 1;
                b_d           = b_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    cout_d  = cell_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; rst is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a cycle model predicts acceptance, handshake
// outputs and {cout,sum}; define SERIAL_ADD_SUB_EN to also exercise subtraction.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [WIDTH:0] sb[$];
    int             m_cnt = 0;
    logic [WIDTH:0] m_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                                  input logic rc, input logic rs);
        logic [WIDTH:0] r;
`ifdef SERIAL_ADD_SUB_EN
        if (rs) r = {1'b0, ra} + {1'b0, ~rb} + (WIDTH+1)'(1);
        else    r = {1'b0, ra} + {1'b0, rb} + (WIDTH+1)'(rc);
`else
        r = {1'b0, ra} + {1'b0, rb} + (WIDTH+1)'(rc);
        if (rs) r = r;
`endif
        return r;
    endfunction

    // Reference timing model: m_cnt = WIDTH+1 right after acceptance, 1 in the done cycle, 0 idle.
    always @(posedge clk) begin
        logic [WIDTH:0] popped;
        if (rst) begin
            m_cnt = 0;
            m_res = '0;
            sb.delete();
        end else if (m_cnt == 0) begin
            if (start) begin
                sb.push_back(ref_result(a, b, cin, sub));
                m_cnt = WIDTH + 1;
            end
        end else begin
            if (m_cnt == 2 && sb.size() > 0) begin
                popped = sb.pop_front();
                m_res  = popped;
            end
            m_cnt = m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ctrl", {29'd0, ready, busy, done}, {29'd0, m_cnt == 0, m_cnt >= 2, m_cnt == 1});
            check("done_busy", {31'd0, done & busy}, 32'd0);
            if (m_cnt <= 1)
                check(m_cnt == 1 ? "result_done" : "result_held", {23'd0, cout, sum}, {23'd0, m_res});
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 4 * WIDTH; i++) begin
            if (m_cnt == 0) return;
            @(negedge clk);
        end
        check("idle_timeout", m_cnt, 0);
    endtask

    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic is);
        wait_idle();
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        sub   = is;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        issue(8'h3C, 8'h05, 1'b0, 1'b0);
        issue(8'hFF, 8'h00, 1'b1, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_idle();
        check("basic_ffff", {23'd0, m_res}, 32'h1FF);

        // start held high with operands changing every cycle
        start = 1'b1;
        for (int i = 0; i < 5 * (WIDTH + 2); i++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // abort in the 4th RUN cycle
        issue(8'hAA, 8'h55, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_sum", {31'd0, sum == '0}, 32'd1);
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        wait_idle();
        check("after_abort", {23'd0, cout, sum}, 32'h002);

        // reset dominates a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        issue(8'h10, 8'h01, 1'b0, 1'b1);
        wait_idle();
        check("sub_10_01", {23'd0, cout, sum}, 32'h10F);
        issue(8'h01, 8'h02, 1'b1, 1'b1);
        wait_idle();
        check("sub_01_02", {23'd0, cout, sum}, 32'h0FF);
`endif

        for (int i = 0; i < 1000; i++)
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        wait_idle();
        repeat (2) @(negedge clk);
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
